// File: rtl/sequential_divider_if.sv
// Start/busy/done bundle for the sequential divider: operands in, registered results out.
interface sequential_divider_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  // start is sampled only while busy is low; results and div_by_zero are
  // valid in the single cycle that done is high and hold until the next done.
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          busy;
  logic          done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, div_by_zero, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, div_by_zero, busy, done
  );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned radix-2 restoring divider producing one quotient bit per clock.
// A result is presented DW+1 cycles after the accepted start, whatever the data.
module sequential_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sequential_divider_if.slave  bus,
  output logic [1:0]           state_dbg
);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW-1:0] r_reg;
  logic [VW-1:0] dvd_lo;
  logic [CW-1:0] cnt;
  logic          dbz;

  // The trial value is one bit wider than the divisor so the compare and
  // subtract cannot overflow; the stored remainder always fits in VW bits.
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;

  assign trial = {r_reg, q_reg[DW-1]};
  assign diff  = trial - {1'b0, d_reg};
  assign fits  = (trial >= {1'b0, d_reg});

  assign state_dbg = state;
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = DIV;
      DIV:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg           <= '0;
      d_reg           <= '0;
      r_reg           <= '0;
      dvd_lo          <= '0;
      cnt             <= '0;
      dbz             <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_reg  <= bus.dividend;
            d_reg  <= bus.divisor;
            dvd_lo <= bus.dividend[VW-1:0];
            r_reg  <= '0;
            cnt    <= '0;
            dbz    <= (bus.divisor == '0);
          end
        end
        DIV: begin
          q_reg <= {q_reg[DW-2:0], fits};
          r_reg <= fits ? diff[VW-1:0] : trial[VW-1:0];
          cnt   <= cnt + 1'b1;
        end
        DONE: begin
          // A zero divisor still runs all iterations; the garbage is replaced here.
          if (dbz) begin
            bus.quotient    <= '1;
            bus.remainder   <= dvd_lo;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.quotient    <= q_reg;
            bus.remainder   <= r_reg;
            bus.div_by_zero <= 1'b0;
          end
          bus.done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: directed vectors plus a short random sweep.
module tb_sequential_divider;
  localparam int DW  = 16;
  localparam int VW  = 8;
  localparam int LAT = DW + 1;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [31:0]   cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         cyc;
  int         n_checks;
  int         n_fail;
  exp_t       exp_q[$];

  sequential_divider_if #(.DW(DW), .VW(VW)) bus ();

  sequential_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // driver: holds start for one edge and records the expected response
  task automatic issue(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                       input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edbz);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.dbz = edbz; e.dvd = dvd; e.dvs = dvs;
    e.cyc = 32'(cyc + LAT);
    exp_q.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edbz);
    issue(dvd, dvs, eq, er, edbz);
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  logic done_prev;
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (done_prev) check("done_one_cycle", 32'(bus.done), 32'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("quotient",    32'(bus.quotient),    32'(e.q));
          check("remainder",   32'(bus.remainder),   32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          check("latency",     32'(cyc),             e.cyc);
          check("busy_at_done", 32'(bus.busy),       32'd0);
          if (e.dvs != '0)
            check("identity", 32'(bus.quotient) * 32'(e.dvs) + 32'(bus.remainder), 32'(e.dvd));
        end
      end
      done_prev = bus.done;
    end else begin
      done_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_quotient",  32'(bus.quotient),    32'd0);
    check("reset_remainder", 32'(bus.remainder),   32'd0);
    check("reset_dbz",       32'(bus.div_by_zero), 32'd0);
    check("reset_done",      32'(bus.done),        32'd0);
    check("reset_busy",      32'(bus.busy),        32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // directed vectors, expected values computed by hand
    run_op(16'd100,  8'd7,   16'd14,     8'd2,    1'b0);
    run_op(16'hFFFF, 8'hFF,  16'h0101,   8'h00,   1'b0);
    run_op(16'hFFFF, 8'h01,  16'hFFFF,   8'h00,   1'b0);
    run_op(16'd3,    8'd10,  16'd0,      8'd3,    1'b0);
    run_op(16'h1234, 8'h00,  16'hFFFF,   8'h34,   1'b1);
    run_op(16'd1000, 8'd33,  16'd30,     8'd10,   1'b0);
    run_op(16'd0,    8'd5,   16'd0,      8'd0,    1'b0);
    run_op(16'd255,  8'd255, 16'd1,      8'd0,    1'b0);
    run_op(16'hFFFF, 8'd2,   16'h7FFF,   8'd1,    1'b0);

    // start pulsed while busy must be ignored; next start lands right after done
    issue(16'd100, 8'd7, 16'd14, 8'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 16'h1234;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_during_op", 32'(bus.busy), 32'd1);
    repeat (LAT - 6) @(posedge clk);
    #1;
    issue(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
    repeat (LAT + 1) @(posedge clk);
    #1;

    // reset in the middle of an operation abandons it without a done pulse
    issue(16'd50, 8'd3, 16'd16, 8'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("midreset_quotient",  32'(bus.quotient),    32'd0);
    check("midreset_remainder", 32'(bus.remainder),   32'd0);
    check("midreset_dbz",       32'(bus.div_by_zero), 32'd0);
    check("midreset_done",      32'(bus.done),        32'd0);
    check("midreset_busy",      32'(bus.busy),        32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (LAT + 8) @(posedge clk);
    #1;
    run_op(16'd200, 8'd9, 16'd22, 8'd2, 1'b0);

    // random back-to-back sweep against a reference model
    for (int i = 0; i < 200; i++) begin
      logic [DW-1:0] dvd;
      logic [VW-1:0] dvs;
      dvd = DW'($urandom_range(0, 65535));
      dvs = (i % 8 == 0) ? '0 : VW'($urandom_range(0, 255));
      if (dvs == '0) issue(dvd, dvs, '1, dvd[VW-1:0], 1'b1);
      else           issue(dvd, dvs, dvd / DW'(dvs), VW'(dvd % DW'(dvs)), 1'b0);
      repeat (LAT) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("outstanding_results", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
